// File: rtl/tmds_channel_decoder_pkg.sv
// Shared TMDS definitions: symbol/data widths, the four control tokens
// and the alignment state encoding used by the channel decoder.
package tmds_pkg;

    localparam int SYMBOL_W = 10;
    localparam int DATA_W   = 8;

    // Control tokens as they appear on the wire, bit 0 received first.
    localparam logic [SYMBOL_W-1:0] TOKEN_C00 = 10'h354;
    localparam logic [SYMBOL_W-1:0] TOKEN_C01 = 10'h0AB;
    localparam logic [SYMBOL_W-1:0] TOKEN_C10 = 10'h154;
    localparam logic [SYMBOL_W-1:0] TOKEN_C11 = 10'h2AB;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_e;

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Bundle between a channel deserializer (master) and the channel decoder
// (slave): raw words go in, decoded pixel stream and alignment status come out.
interface tmds_channel_decoder_if
    import tmds_pkg::*;
();

    logic [SYMBOL_W-1:0] din;
    logic                de;
    logic [1:0]          ctrl;
    logic [DATA_W-1:0]   data;
    logic                locked;
    logic [3:0]          offset;

    modport master (
        output din,
        input  de, ctrl, data, locked, offset
    );

    modport slave (
        input  din,
        output de, ctrl, data, locked, offset
    );

endinterface

// File: rtl/tmds_channel_decoder_symbol_decode.sv
// Purely combinational TMDS symbol decoder: classifies a 10-bit symbol as a
// control token (with its 2-bit code) and undoes the transition-minimising
// data encoding. Kept separate so island/audio decoding can reuse it.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYMBOL_W-1:0] symbol,
    output logic                is_token,
    output logic [1:0]          ctrl,
    output logic [DATA_W-1:0]   data
);

    logic [DATA_W-1:0] unmasked;

    // Match the symbol against the four control tokens.
    always_comb begin
        is_token = 1'b1;
        ctrl     = 2'b00;
        case (symbol)
            TOKEN_C00: ctrl = 2'b00;
            TOKEN_C01: ctrl = 2'b01;
            TOKEN_C10: ctrl = 2'b10;
            TOKEN_C11: ctrl = 2'b11;
            default:   is_token = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    always_comb begin
        unmasked = symbol[DATA_W-1:0] ^ {DATA_W{symbol[9]}};
        data     = '0;
        data[0]  = unmasked[0];
        for (int i = 1; i < DATA_W; i++) begin
            data[i] = symbol[8] ? (unmasked[i] ^ unmasked[i-1])
                                : ~(unmasked[i] ^ unmasked[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: bit-slips the raw deserializer words until runs
// of control tokens line up, then decodes the aligned symbols into DE,
// control code and data byte with a two-register pipeline.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_CYCLES = 2048
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    tmds_channel_decoder_if.slave bus
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
    localparam int TCNT_W = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;

    localparam logic [RUN_W-1:0]  RUN_FULL   = RUN_W'(LOCK_TOKENS);
    localparam logic [RUN_W-1:0]  RUN_ALMOST = RUN_W'(LOCK_TOKENS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(SEARCH_CYCLES - 1);
    localparam logic [3:0]        OFFSET_MAX = 4'd9;

    logic [SYMBOL_W-1:0]   prev;
    logic [2*SYMBOL_W-1:0] window;
    logic [SYMBOL_W-1:0]   aligned;
    logic [SYMBOL_W-1:0]   stage1;

    logic                  s1_is_token;
    logic [1:0]            s1_ctrl;
    logic [DATA_W-1:0]     s1_data;

    logic [RUN_W-1:0]      run;
    logic [TCNT_W-1:0]     tcnt;
    logic                  stale;
    tmds_state_e           state;
    logic [3:0]            offset;

    logic                  de_q;
    logic [1:0]            ctrl_q;
    logic [DATA_W-1:0]     data_q;

    logic                  count_ok;
    logic                  run_hit;
    logic                  timeout;

    // The previous word sits in the low half so bit 0 is the oldest bit.
    assign window = {bus.din, prev};

    // Pick the 10-bit symbol starting at the current slip offset.
    always_comb begin
        aligned = window[SYMBOL_W-1:0];
        for (int k = 0; k < SYMBOL_W; k++) begin
            if (offset == 4'(k)) begin
                aligned = window[k +: SYMBOL_W];
            end
        end
    end

    // Capture the last raw word and the aligned symbol (pipeline stage 1).
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            prev   <= '0;
            stage1 <= '0;
        end else begin
            prev   <= bus.din;
            stage1 <= aligned;
        end
    end

    tmds_symbol_decode u_decode (
        .symbol   (stage1),
        .is_token (s1_is_token),
        .ctrl     (s1_ctrl),
        .data     (s1_data)
    );

    // A word captured under the old offset right after a slip must not count.
    assign count_ok = s1_is_token && !stale;
    assign run_hit  = count_ok && (run >= RUN_ALMOST);
    assign timeout  = (tcnt == TCNT_LAST);

    // Token-run and timeout tracking; a completed run outranks a timeout.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            run    <= '0;
            tcnt   <= '0;
            stale  <= 1'b0;
            state  <= SEARCH;
            offset <= '0;
        end else if (run_hit) begin
            run   <= RUN_FULL;
            tcnt  <= '0;
            stale <= 1'b0;
            state <= LOCKED;
        end else if (timeout) begin
            run    <= '0;
            tcnt   <= '0;
            stale  <= 1'b1;
            state  <= SEARCH;
            offset <= (offset == OFFSET_MAX) ? 4'd0 : offset + 4'd1;
        end else begin
            tcnt  <= tcnt + 1'b1;
            stale <= 1'b0;
            run   <= count_ok ? run + 1'b1 : '0;
        end
    end

    // Register the decoded symbol (stage 2), blanked while unaligned.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            data_q <= '0;
        end else if (state != LOCKED) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            data_q <= '0;
        end else if (s1_is_token) begin
            de_q   <= 1'b0;
            ctrl_q <= s1_ctrl;
            data_q <= '0;
        end else begin
            de_q   <= 1'b1;
            ctrl_q <= 2'b00;
            data_q <= s1_data;
        end
    end

    assign bus.de     = de_q;
    assign bus.ctrl   = ctrl_q;
    assign bus.data   = data_q;
    assign bus.locked = (state == LOCKED);
    assign bus.offset = offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: alignment, bit-slip,
// decode through a scoreboard, loss of lock, timeout/run collision, reset.
module tb_tmds_channel_decoder;

    localparam int LT = 8;
    localparam int SC = 64;

    localparam logic [9:0] TOK00 = 10'h354;
    localparam logic [9:0] TOK01 = 10'h0AB;
    localparam logic [9:0] TOK10 = 10'h154;
    localparam logic [9:0] TOK11 = 10'h2AB;
    localparam logic [9:0] DATA0 = 10'h100;

    typedef struct packed {
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } out_t;

    logic clk_pixel = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    out_t sb_q[$];

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .LOCK_TOKENS   (LT),
        .SEARCH_CYCLES (SC)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    // Free-running pixel clock.
    always #5 clk_pixel = ~clk_pixel;

    // Hard stop in case a wait loop misbehaves.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic out_t obs();
        return {bus.de, bus.ctrl, bus.data};
    endfunction

    // Word that places the aligned symbol at slip offset k.
    function automatic logic [9:0] skew(input logic [9:0] sym, input int k);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = sym[(i - k + 10) % 10];
        return r;
    endfunction

    // Reference TMDS data encoder (transition minimising stage + inversion).
    function automatic logic [9:0] encode(input logic [7:0] d, input logic xm, input logic inv);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xm ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return {inv, xm, qm ^ {8{inv}}};
    endfunction

    // Expected locked output for a word whose plain byte is b.
    function automatic out_t expect_word(input logic [9:0] w, input logic [7:0] b);
        case (w)
            TOK00:   return {1'b0, 2'b00, 8'h00};
            TOK01:   return {1'b0, 2'b01, 8'h00};
            TOK10:   return {1'b0, 2'b10, 8'h00};
            TOK11:   return {1'b0, 2'b11, 8'h00};
            default: return {1'b1, 2'b00, b};
        endcase
    endfunction

    task automatic step(input logic [9:0] w);
        @(negedge clk_pixel);
        bus.din = w;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic step_release(input logic [9:0] w);
        @(negedge clk_pixel);
        bus.din = w;
        reset   = 1'b0;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic hold_reset();
        @(negedge clk_pixel);
        reset   = 1'b1;
        bus.din = '0;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        bus.din = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1;
        checks++;
        if (obs() !== out_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs(), out_t'(0));
        end
        checks++;
        if ({bus.locked, bus.offset} !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: got locked=%b offset=%0d expected 0/0", bus.locked, bus.offset);
        end
    endtask

    task automatic test_already_aligned();
        for (int e = 1; e <= LT + 3; e++) begin
            if (e == 1) step_release(TOK10);
            else step(TOK10);
            if (e == LT + 1) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL aligned_early: got locked=%b expected 0 at cycle %0d", bus.locked, e);
                end
            end
            if (e == LT + 2) begin
                checks++;
                if ({bus.locked, bus.offset} !== {1'b1, 4'd0}) begin
                    errors++;
                    $display("[TB] FAIL aligned_lock: got locked=%b offset=%0d expected 1/0", bus.locked, bus.offset);
                end
            end
            if (e == LT + 3) begin
                checks++;
                if (obs() !== out_t'({1'b0, 2'b10, 8'h00})) begin
                    errors++;
                    $display("[TB] FAIL aligned_ctrl: got %h expected %h", obs(), out_t'({1'b0, 2'b10, 8'h00}));
                end
            end
        end
    endtask

    task automatic test_data_decode();
        logic [9:0] fixed_w [4];
        logic [7:0] fixed_b [4];
        logic [9:0] w;
        logic [7:0] b;
        out_t       want;
        fixed_w = '{10'h100, 10'h200, 10'h0AB, 10'h2AB};
        fixed_b = '{8'h00, 8'hFF, 8'h00, 8'h00};
        sb_q.delete();
        for (int n = 0; n < 32; n++) begin
            if (n < 4) begin
                w = fixed_w[n];
                b = fixed_b[n];
            end else if (n < 20) begin
                b = 8'($urandom_range(0, 255));
                w = encode(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                w = TOK10;
                b = 8'h00;
            end
            step(w);
            sb_q.push_back(expect_word(w, b));
            if (sb_q.size() > 2) begin
                want = sb_q.pop_front();
                checks++;
                if (obs() !== want) begin
                    errors++;
                    $display("[TB] FAIL decode_%0d: got %h expected %h (word %h)", n - 2, obs(), want, w);
                end
            end
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL decode_locked: got locked=%b expected 1", bus.locked);
        end
    endtask

    task automatic test_reset_mid_lock();
        @(posedge clk_pixel);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.locked, bus.offset, obs()} !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_lock: got locked=%b offset=%0d out=%h expected all 0", bus.locked, bus.offset, obs());
        end
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_loss_of_lock();
        int drop_at;
        int lock_at;
        lock_at = 0;
        for (int e = 1; e <= LT + 6; e++) begin
            if (e == 1) step_release(TOK10);
            else step(TOK10);
            if (lock_at == 0 && bus.locked === 1'b1) lock_at = e;
        end
        checks++;
        if (lock_at == 0) begin
            errors++;
            $display("[TB] FAIL loss_initial_lock: got locked=%b expected 1", bus.locked);
        end
        drop_at = 0;
        for (int e = 1; e <= SC + 6; e++) begin
            step(DATA0);
            if (drop_at == 0 && bus.locked === 1'b0) drop_at = e;
        end
        checks++;
        if (drop_at < SC || drop_at > SC + 3) begin
            errors++;
            $display("[TB] FAIL loss_drop_time: got drop at data word %0d expected %0d..%0d", drop_at, SC, SC + 3);
        end
        checks++;
        if (bus.offset !== 4'd1) begin
            errors++;
            $display("[TB] FAIL loss_offset: got %0d expected 1", bus.offset);
        end
        lock_at = 0;
        for (int e = 1; e <= LT + 6; e++) begin
            step(skew(TOK10, 1));
            if (lock_at == 0 && bus.locked === 1'b1) lock_at = e;
        end
        checks++;
        if (lock_at == 0 || bus.offset !== 4'd1) begin
            errors++;
            $display("[TB] FAIL loss_relock: got locked=%b offset=%0d expected 1/1", bus.locked, bus.offset);
        end
        checks++;
        if (obs() !== out_t'({1'b0, 2'b10, 8'h00})) begin
            errors++;
            $display("[TB] FAIL loss_relock_ctrl: got %h expected %h", obs(), out_t'({1'b0, 2'b10, 8'h00}));
        end
    endtask

    task automatic test_bit_slip();
        int lock_at;
        logic [3:0] lock_off;
        lock_at  = 0;
        lock_off = '0;
        hold_reset();
        for (int e = 1; e <= 3 * SC + LT + 4; e++) begin
            if (e == 1) step_release(skew(TOK10, 3));
            else step(skew(TOK10, 3));
            if (e == SC - 1 || e == SC || e == 2 * SC || e == 3 * SC) begin
                checks++;
                if (bus.offset !== 4'(e / SC) || bus.locked !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL slip_step_%0d: got offset=%0d locked=%b expected %0d/0", e, bus.offset, bus.locked, e / SC);
                end
            end
            if (lock_at == 0 && bus.locked === 1'b1) begin
                lock_at  = e;
                lock_off = bus.offset;
            end
        end
        checks++;
        if (lock_at == 0 || lock_off !== 4'd3) begin
            errors++;
            $display("[TB] FAIL slip_lock: got lock cycle %0d offset %0d expected lock with offset 3", lock_at, lock_off);
        end
    endtask

    task automatic test_simultaneous();
        hold_reset();
        for (int e = 1; e <= SC + 3; e++) begin
            if (e == 1) step_release(DATA0);
            else step((e >= SC - LT - 1) ? TOK10 : DATA0);
            if (e == SC - 1) begin
                checks++;
                if ({bus.locked, bus.offset} !== {1'b0, 4'd0}) begin
                    errors++;
                    $display("[TB] FAIL simul_before: got locked=%b offset=%0d expected 0/0", bus.locked, bus.offset);
                end
            end
            if (e == SC || e == SC + 3) begin
                checks++;
                if ({bus.locked, bus.offset} !== {1'b1, 4'd0}) begin
                    errors++;
                    $display("[TB] FAIL simul_cycle_%0d: got locked=%b offset=%0d expected 1/0", e, bus.locked, bus.offset);
                end
            end
        end
    endtask

    task automatic test_offset_wrap();
        hold_reset();
        for (int e = 1; e <= 10 * SC; e++) begin
            if (e == 1) step_release(DATA0);
            else step(DATA0);
            if (e == 9 * SC || e == 10 * SC) begin
                checks++;
                if (bus.offset !== 4'((e / SC) % 10)) begin
                    errors++;
                    $display("[TB] FAIL wrap_cycle_%0d: got offset=%0d expected %0d", e, bus.offset, (e / SC) % 10);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_already_aligned();
        test_data_decode();
        test_reset_mid_lock();
        test_loss_of_lock();
        test_bit_slip();
        test_simultaneous();
        test_offset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
